// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/flush/hold control for the 5-stage MIPS pipe.
// Ports: clk, rst (sync, active-high), cpu_en, id_instruction,
//   id_branch_taken, mem_ready -> pc_we, id_shouldStall,
//   id_shouldJumpOrBranch, ex_bubble, pipe_hold, mem_fault, stall_count.
// Optional macro HAZARD_FORWARD_EN: forwarding-aware hazard rule.
module hazard_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_en,
  input  logic [31:0]      id_instruction,
  input  logic             id_branch_taken,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             id_shouldStall,
  output logic             id_shouldJumpOrBranch,
  output logic             ex_bubble,
  output logic             pipe_hold,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
    logic       is_mem;
  } sb_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_FAULT
  } state_e;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = id_instruction[31:26];
  assign rs    = id_instruction[25:21];
  assign rt    = id_instruction[20:16];
  assign rd    = id_instruction[15:11];
  assign funct = id_instruction[5:0];

  logic unused_shamt;
  assign unused_shamt = ^id_instruction[10:6];

  logic is_r;
  logic is_jr;
  logic is_alu_r;
  logic is_ialu;
  logic is_lw;
  logic is_sw;
  logic is_bx;
  logic is_j;
  logic is_jal;

  assign is_r     = (op == OP_R);
  assign is_jr    = is_r && (funct == FN_JR);
  assign is_alu_r = is_r && (funct != FN_JR);
  assign is_ialu  = (op[5:3] == 3'b001);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_bx    = (op == OP_BEQ) || (op == OP_BNE);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);

  sb_t  id_e;
  logic use_rs;
  logic use_rt;

  always_comb begin
    id_e   = '0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    unique case (1'b1)
      is_alu_r: begin
        id_e.dest = rd;
        use_rs    = 1'b1;
        use_rt    = 1'b1;
      end
      is_jr: begin
        use_rs = 1'b1;
      end
      is_ialu: begin
        id_e.dest = rt;
        use_rs    = 1'b1;
      end
      is_lw: begin
        id_e.dest    = rt;
        id_e.is_load = 1'b1;
        id_e.is_mem  = 1'b1;
        use_rs       = 1'b1;
      end
      is_sw: begin
        id_e.is_mem = 1'b1;
        use_rs      = 1'b1;
        use_rt      = 1'b1;
      end
      is_bx: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      is_jal: begin
        id_e.dest = 5'd31;
      end
      default: ;
    endcase
    id_e.valid = (id_e.dest != 5'd0) || id_e.is_mem;
  end

  sb_t ex_q, ex_d;
  sb_t mem_q, mem_d;

  state_e state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // $0 as a destination is filtered here, so it never matches.
  logic ex_hit;
  logic mem_hit;

  assign ex_hit = ex_q.valid && (ex_q.dest != 5'd0) &&
    ((use_rs && (rs == ex_q.dest)) ||
     (use_rt && (rt == ex_q.dest)));

  assign mem_hit = mem_q.valid && (mem_q.dest != 5'd0) &&
    ((use_rs && (rs == mem_q.dest)) ||
     (use_rt && (rt == mem_q.dest)));

  // Branches and jr resolve in ID, so they need operands earlier.
  logic id_chk;
  assign id_chk = is_bx || is_jr;

  logic hazard;
`ifdef HAZARD_FORWARD_EN
  assign hazard = (ex_hit && ex_q.is_load) ||
                  (id_chk && ex_hit) ||
                  (id_chk && mem_hit && mem_q.is_load);
`else
  logic unused_chk;
  assign unused_chk = id_chk;
  assign hazard = ex_hit || mem_hit;
`endif

  logic ctl_xfer;
  assign ctl_xfer = is_j || is_jal || is_jr ||
                    (is_bx && id_branch_taken);

  logic mem_block;
  assign mem_block = mem_q.valid && mem_q.is_mem && !mem_ready;

  logic mem_wait;
  assign mem_wait = (state_q != S_RUN) || mem_block;

  always_comb begin
    pc_we                 = 1'b1;
    id_shouldStall        = 1'b0;
    id_shouldJumpOrBranch = 1'b0;
    ex_bubble             = 1'b0;
    pipe_hold             = 1'b0;
    if (mem_wait) begin
      pc_we          = 1'b0;
      id_shouldStall = 1'b1;
      pipe_hold      = 1'b1;
    end else if (hazard) begin
      pc_we          = 1'b0;
      id_shouldStall = 1'b1;
      ex_bubble      = 1'b1;
    end else if (ctl_xfer) begin
      id_shouldStall        = 1'b1;
      id_shouldJumpOrBranch = 1'b1;
    end
  end

  assign mem_fault   = (state_q == S_FAULT);
  assign stall_count = cnt_q;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    if (cpu_en) begin
      unique case (state_q)
        S_RUN: begin
          if (mem_block) begin
            state_d = S_MEM_WAIT;
            tmo_d   = 16'd1;
          end
        end
        S_MEM_WAIT: begin
          if (mem_ready) begin
            state_d = S_RUN;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 16'd1;
            if (tmo_d == TMO) begin
              state_d = S_FAULT;
            end
          end
        end
        S_FAULT: ;
        default: state_d = S_RUN;
      endcase
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (cpu_en && !pipe_hold) begin
      mem_d = ex_q;
      ex_d  = ex_bubble ? '0 : id_e;
    end
    if (cpu_en && id_shouldStall) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      tmo_q   <= '0;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed scenarios plus random stimulus
// checked against an instruction-level model of the hazard unit.
module tb_hazard_control_unit;

  localparam int T = 4;

`ifdef HAZARD_FORWARD_EN
  localparam int NF = 0;
`else
  localparam int NF = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [31:0] id_instruction;
  logic        id_branch_taken;
  logic        mem_ready;
  logic        pc_we;
  logic        id_shouldStall;
  logic        id_shouldJumpOrBranch;
  logic        ex_bubble;
  logic        pipe_hold;
  logic        mem_fault;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(
    .MEM_TIMEOUT(T),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_en(cpu_en),
    .id_instruction(id_instruction),
    .id_branch_taken(id_branch_taken),
    .mem_ready(mem_ready),
    .pc_we(pc_we),
    .id_shouldStall(id_shouldStall),
    .id_shouldJumpOrBranch(id_shouldJumpOrBranch),
    .ex_bubble(ex_bubble),
    .pipe_hold(pipe_hold),
    .mem_fault(mem_fault),
    .stall_count(stall_count)
  );

  // {pc_we, stall, jump, bubble, hold, fault}
  logic [5:0] outs;
  assign outs = {pc_we, id_shouldStall, id_shouldJumpOrBranch,
                 ex_bubble, pipe_hold, mem_fault};

  localparam logic [5:0] O_RUN  = 6'b100000;
  localparam logic [5:0] O_HAZ  = 6'b010100;
  localparam logic [5:0] O_XFER = 6'b111000;
  localparam logic [5:0] O_WAIT = 6'b010010;
  localparam logic [5:0] O_FLT  = 6'b010011;

  function automatic logic [31:0] r_ins(int d, int s, int t, logic [5:0] fn);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, int s, int t, int imm);
    return {op, 5'(s), 5'(t), 16'(imm)};
  endfunction

  task automatic cyc(input logic r, input logic e, input logic [31:0] ins,
                     input logic tk, input logic rdy);
    @(negedge clk);
    rst             = r;
    cpu_en          = e;
    id_instruction  = ins;
    id_branch_taken = tk;
    mem_ready       = rdy;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ex, m_mem;
  bit          m_exv, m_memv, m_wait, m_fault;
  int          m_wcnt;
  logic [15:0] m_cnt;

  function automatic int f_op(logic [31:0] i);  return int'(i[31:26]); endfunction
  function automatic bit f_jr(logic [31:0] i);
    return i[31:26] == 6'h00 && i[5:0] == 6'h08;
  endfunction
  function automatic int f_dst(logic [31:0] i);
    int op = f_op(i);
    if (op == 0) return f_jr(i) ? 0 : int'(i[15:11]);
    if ((op >= 8 && op <= 15) || op == 'h23) return int'(i[20:16]);
    if (op == 3) return 31;
    return 0;
  endfunction
  function automatic bit f_rs(logic [31:0] i);
    int op = f_op(i);
    return op == 0 || (op >= 8 && op <= 15) || op == 'h23 ||
           op == 'h2b || op == 4 || op == 5;
  endfunction
  function automatic bit f_rt(logic [31:0] i);
    int op = f_op(i);
    return (op == 0 && !f_jr(i)) || op == 'h2b || op == 4 || op == 5;
  endfunction
  function automatic bit f_reads(logic [31:0] i, int d);
    if (d == 0) return 0;
    return (f_rs(i) && int'(i[25:21]) == d) ||
           (f_rt(i) && int'(i[20:16]) == d);
  endfunction
  function automatic bit f_load(logic [31:0] i); return f_op(i) == 'h23; endfunction
  function automatic bit f_mem(logic [31:0] i);
    return f_op(i) == 'h23 || f_op(i) == 'h2b;
  endfunction
  function automatic bit f_early(logic [31:0] i);
    return f_op(i) == 4 || f_op(i) == 5 || f_jr(i);
  endfunction

  function automatic logic [31:0] rand_ins();
    int r[3];
    for (int n = 0; n < 3; n++) begin
      int v = $urandom_range(0, 4);
      r[n] = (v == 4) ? 31 : v;
    end
    case ($urandom_range(0, 11))
      0:       return r_ins(r[0], r[1], r[2], 6'h20);
      1:       return r_ins(0, r[1], 0, 6'h08);
      2:       return i_ins(6'h08, r[1], r[0], 7);
      3:       return i_ins(6'h0f, 0, r[0], 1);
      4, 5:    return i_ins(6'h23, r[1], r[0], 0);
      6:       return i_ins(6'h2b, r[1], r[2], 0);
      7:       return i_ins(6'h04, r[1], r[2], 2);
      8:       return i_ins(6'h05, r[1], r[2], 2);
      9:       return {6'h02, 26'd40};
      10:      return {6'h03, 26'd80};
      default: return {6'h3f, 26'h155};
    endcase
  endfunction

  // ---------------- directed tests ----------------
  task automatic test_reset();
    cyc(1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    checks++;
    if (outs !== O_RUN) begin
      failures++;
      $display("FAIL reset_outs: got %b want %b", outs, O_RUN);
    end
    checks++;
    if (stall_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d want 0", stall_count);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] lw  = i_ins(6'h23, 9, 8, 0);
    logic [31:0] add = r_ins(10, 8, 11, 6'h20);
    logic [5:0]  exp;
    do_reset();
    cyc(1'b0, 1'b1, lw, 1'b0, 1'b1);
    checks++;
    if (outs !== O_RUN) begin
      failures++;
      $display("FAIL lu_issue: got %b want %b", outs, O_RUN);
    end
    for (int k = 0; k <= NF + 1; k++) begin
      cyc(1'b0, 1'b1, add, 1'b0, 1'b1);
      exp = (k <= NF) ? O_HAZ : O_RUN;
      checks++;
      if (outs !== exp) begin
        failures++;
        $display("FAIL lu_c%0d: got %b want %b", k, outs, exp);
      end
    end
    checks++;
    if (stall_count !== 16'(NF + 1)) begin
      failures++;
      $display("FAIL lu_cnt: got %0d want %0d", stall_count, NF + 1);
    end
  endtask

  task automatic test_branch();
    logic [31:0] beq  = i_ins(6'h04, 1, 2, 4);
    logic [31:0] j    = {6'h02, 26'd100};
    logic [31:0] addi = i_ins(6'h08, 0, 1, 5);
    logic [5:0]  exp;
    do_reset();
    cyc(1'b0, 1'b1, beq, 1'b1, 1'b1);
    checks++;
    if (outs !== O_XFER) begin
      failures++;
      $display("FAIL br_taken: got %b want %b", outs, O_XFER);
    end
    cyc(1'b0, 1'b1, j, 1'b0, 1'b1);
    checks++;
    if (outs !== O_XFER) begin
      failures++;
      $display("FAIL br_j: got %b want %b", outs, O_XFER);
    end
    cyc(1'b0, 1'b1, beq, 1'b0, 1'b1);
    checks++;
    if (outs !== O_RUN) begin
      failures++;
      $display("FAIL br_not_taken: got %b want %b", outs, O_RUN);
    end
    cyc(1'b0, 1'b1, addi, 1'b0, 1'b1);
    for (int k = 0; k <= NF + 1; k++) begin
      cyc(1'b0, 1'b1, beq, 1'b1, 1'b1);
      exp = (k <= NF) ? O_HAZ : O_XFER;
      checks++;
      if (outs !== exp) begin
        failures++;
        $display("FAIL br_mask_c%0d: got %b want %b", k, outs, exp);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [31:0] lw   = i_ins(6'h23, 9, 8, 0);
    logic [31:0] addi = i_ins(6'h08, 0, 1, 5);
    logic [31:0] beq  = i_ins(6'h04, 1, 2, 4);
    do_reset();
    cyc(1'b0, 1'b1, lw, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, addi, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      checks++;
      if (outs !== O_WAIT) begin
        failures++;
        $display("FAIL mw_c%0d: got %b want %b", k, outs, O_WAIT);
      end
    end
    // Cycle where ready returns: FSM still in the wait state.
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    checks++;
    if (outs !== O_WAIT) begin
      failures++;
      $display("FAIL mw_ready: got %b want %b", outs, O_WAIT);
    end
    // addi $1 must still sit in EX if the scoreboard froze.
    cyc(1'b0, 1'b1, beq, 1'b1, 1'b1);
    checks++;
    if (outs !== O_HAZ) begin
      failures++;
      $display("FAIL mw_frozen: got %b want %b", outs, O_HAZ);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] lw = i_ins(6'h23, 9, 8, 0);
    logic [5:0]  exp;
    do_reset();
    cyc(1'b0, 1'b1, lw, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b1, 32'h0, 1'b0, k == 5);
      exp = (k >= T) ? O_FLT : O_WAIT;
      checks++;
      if (outs !== exp) begin
        failures++;
        $display("FAIL to_c%0d: got %b want %b", k, outs, exp);
      end
    end
    do_reset();
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    checks++;
    if (outs !== O_RUN) begin
      failures++;
      $display("FAIL to_rst: got %b want %b", outs, O_RUN);
    end
  endtask

  task automatic test_cpu_en();
    logic [31:0] lw  = i_ins(6'h23, 9, 8, 0);
    logic [31:0] add = r_ins(10, 8, 11, 6'h20);
    logic [5:0]  exp;
    do_reset();
    cyc(1'b0, 1'b1, lw, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, add, 1'b0, 1'b1);
      checks++;
      if (outs !== O_HAZ) begin
        failures++;
        $display("FAIL en_off_c%0d: got %b want %b", k, outs, O_HAZ);
      end
    end
    checks++;
    if (stall_count !== 16'd0) begin
      failures++;
      $display("FAIL en_off_cnt: got %0d want 0", stall_count);
    end
    for (int k = 0; k <= NF + 1; k++) begin
      cyc(1'b0, 1'b1, add, 1'b0, 1'b1);
      exp = (k <= NF) ? O_HAZ : O_RUN;
      checks++;
      if (outs !== exp) begin
        failures++;
        $display("FAIL en_on_c%0d: got %b want %b", k, outs, exp);
      end
    end
    checks++;
    if (stall_count !== 16'(NF + 1)) begin
      failures++;
      $display("FAIL en_cnt: got %0d want %0d", stall_count, NF + 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic        r, e, tk, rdy;
    bit          mc, waitv, haz, xfer;
    logic [5:0]  exp;
    do_reset();
    m_exv = 0; m_memv = 0; m_wait = 0; m_fault = 0;
    m_wcnt = 0; m_cnt = '0; m_ex = '0; m_mem = '0;
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 99) < 3);
      e   = ($urandom_range(0, 99) < 85);
      tk  = $urandom_range(0, 1) == 1;
      rdy = ($urandom_range(0, 99) < 85);
      ins = rand_ins();
      cyc(r, e, ins, tk, rdy);
      mc    = m_memv && f_mem(m_mem) && !rdy;
      waitv = m_fault || m_wait || mc;
`ifdef HAZARD_FORWARD_EN
      haz = (m_exv && f_load(m_ex) && f_reads(ins, f_dst(m_ex))) ||
            (f_early(ins) && m_exv && f_reads(ins, f_dst(m_ex))) ||
            (f_early(ins) && m_memv && f_load(m_mem) &&
             f_reads(ins, f_dst(m_mem)));
`else
      haz = (m_exv && f_reads(ins, f_dst(m_ex))) ||
            (m_memv && f_reads(ins, f_dst(m_mem)));
`endif
      xfer = f_op(ins) == 2 || f_op(ins) == 3 || f_jr(ins) ||
             ((f_op(ins) == 4 || f_op(ins) == 5) && tk);
      if (waitv)     exp = {5'b01001, m_fault};
      else if (haz)  exp = O_HAZ;
      else if (xfer) exp = O_XFER;
      else           exp = O_RUN;
      checks++;
      if (outs !== exp) begin
        failures++;
        $display("FAIL rnd_outs n=%0d ins=%h: got %b want %b",
                 n, ins, outs, exp);
      end
      checks++;
      if (stall_count !== m_cnt) begin
        failures++;
        $display("FAIL rnd_cnt n=%0d: got %0d want %0d",
                 n, stall_count, m_cnt);
      end
      if (r) begin
        m_exv = 0; m_memv = 0; m_wait = 0; m_fault = 0;
        m_wcnt = 0; m_cnt = '0;
      end else if (e) begin
        if (exp[4]) m_cnt = m_cnt + 16'd1;
        if (m_fault) begin
        end else if (m_wait) begin
          if (rdy) m_wait = 0;
          else begin
            m_wcnt++;
            if (m_wcnt == T) begin
              m_fault = 1;
              m_wait  = 0;
            end
          end
        end else if (mc) begin
          m_wait = 1;
          m_wcnt = 1;
        end
        if (!waitv) begin
          m_mem  = m_ex;
          m_memv = m_exv;
          m_ex   = ins;
          m_exv  = !haz;
        end
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    cpu_en          = 1'b1;
    id_instruction  = 32'h0;
    id_branch_taken = 1'b0;
    mem_ready       = 1'b1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_cpu_en();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Produces the stall, flush and hold controls consumed by the IF/ID, ID/EX and later pipeline registers and by the PC register of the 5-stage MIPS pipeline.
- Decodes the instruction sitting in ID and keeps an internal scoreboard of in-flight writers in EX and MEM.
- Sequences memory-wait stalls with a timeout FSM.
- Drives id_shouldStall and id_shouldJumpOrBranch with the same semantics the IF/ID register expects. Flush is signalled as stall plus jump together.

Parameters:
MEM_TIMEOUT, 64, max consecutive cycles mem_ready may stay low before mem_fault is raised (2..65535)
CNT_W, 32, width of stall_count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_en  in  1  global step enable; when 0 no internal state updates
id_instruction  in  32  instruction currently in ID
id_branch_taken  in  1  ID-stage comparator result for beq/bne
mem_ready  in  1  data memory ready; relevant only when the MEM entry is a load/store
pc_we  out  1  PC write enable
id_shouldStall  out  1  IF/ID hold
id_shouldJumpOrBranch  out  1  with id_shouldStall=1: zero the IF/ID instruction (flush)
ex_bubble  out  1  load a nop into ID/EX
pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB
mem_fault  out  1  sticky memory-timeout flag
stall_count  out  CNT_W  cycles with id_shouldStall=1 and cpu_en=1, wraps

Behaviour:
- Decode uses op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
  - Dest: R-type (op 0) -> rd, except jr (funct 001000), which has none.
  - Dest: addi/addiu/slti/sltiu/andi/ori/xori/lui/lw -> rt.
  - Dest: jal -> 31.
  - Dest: sw/beq/bne/j -> none.
  - Sources: R-type rs,rt; I-ALU and lw rs; sw/beq/bne rs,rt; jr rs; j/jal none.
  - Register 0 never creates a hazard.
- Scoreboard: two entries, EX and MEM, each {valid, dest[4:0], is_load, is_mem}.
  - Advances when cpu_en=1 and pipe_hold=0: MEM<=EX, EX<=ID entry or empty.
  - EX becomes empty when ex_bubble=1.
- Hazard (forwarding build; see Optional Feature):
  - EX.is_load and EX.dest matches an ID source; or
  - ID is beq/bne/jr and EX.dest matches a source; or
  - ID is beq/bne/jr and MEM.is_load with MEM.dest matching a source.
- FSM states: RUN, MEM_WAIT, FAULT.
  - RUN -> MEM_WAIT when MEM.valid & MEM.is_mem & !mem_ready; the timeout counter loads 1.
  - MEM_WAIT -> RUN on mem_ready=1.
  - MEM_WAIT: the counter increments each cpu_en cycle; it goes to FAULT when the counter reaches MEM_TIMEOUT with mem_ready still 0.
  - FAULT is exited only by rst.
  - All transitions are gated by cpu_en.
- Outputs are combinational. Priority is highest first:
  1. Mem wait: FSM in MEM_WAIT or FAULT, or the RUN->MEM_WAIT condition true -> pc_we=0, stall=1, jump=0, ex_bubble=0, pipe_hold=1.
  2. Data hazard -> pc_we=0, stall=1, jump=0, ex_bubble=1, pipe_hold=0.
  3. Control transfer: j/jal/jr, or beq/bne with id_branch_taken -> pc_we=1, stall=1, jump=1, ex_bubble=0, pipe_hold=0.
  4. Otherwise: pc_we=1, all others 0.
- A hazard masks a simultaneous taken branch; the branch re-evaluates next cycle.
- mem_fault=1 iff state==FAULT.
- Reset: scoreboard empty, state RUN, timeout counter 0, stall_count 0. With id_instruction=0 this gives pc_we=1 and all other outputs 0.
- Reset mid MEM_WAIT or FAULT returns to RUN the next cycle.
- cpu_en=0:
  - Outputs are still computed.
  - Scoreboard, FSM, timeout counter and stall_count hold.

Optional Feature:
- Macro: HAZARD_FORWARD_EN
- Defined: the hazard rule above applies (forwarding paths present; a load-use hazard costs 1 stall cycle).
- Undefined: a hazard is any valid EX or MEM entry whose dest matches an ID source, regardless of type.
  - A dependent ALU instruction stalls 2 cycles behind its producer.
  - The register file is write-through, so WB is never checked.

Test Plan:
- rst=1, then release with id_instruction=0 -> pc_we=1, all others 0, stall_count=0, mem_fault=0.
- lw $8,0($9) issued, next ID=add $10,$8,$11 (forwarding build), mem_ready=1 -> exactly one cycle of stall=1, ex_bubble=1, pc_we=0; then normal; stall_count=1.
- ID=beq $1,$2 with id_branch_taken=1 and no hazard -> stall=1, jump=1, pc_we=1 for one cycle. A j in ID gives the same response.
- lw reaches MEM with mem_ready=0 for 3 cycles, MEM_TIMEOUT=64 -> pipe_hold=1 and pc_we=0 for those 3 cycles, scoreboard frozen; resumes on mem_ready=1; mem_fault stays 0.
- mem_ready held 0 with MEM_TIMEOUT=4 -> mem_fault=1 after 4 waiting cycles; pipe_hold stays 1; rst clears mem_fault to 0.
- cpu_en=0 for 5 cycles during a load-use hazard -> scoreboard and stall_count unchanged; the hazard resolves after 1 enabled cycle once cpu_en=1.
